// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// ram_port_arbiter : round-robin two-port front end for a single-port RAM
// Rev 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH),
  localparam int SW    = WIDTH / 8
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_m0_req,
  input  logic             i_m0_we,
  input  logic [AW-1:0]    i_m0_addr,
  input  logic [WIDTH-1:0] i_m0_wdata,
  input  logic [SW-1:0]    i_m0_wstrb,
  output logic             o_m0_gnt,
  output logic             o_m0_rvalid,
  output logic [WIDTH-1:0] o_m0_rdata,
  input  logic             i_m1_req,
  input  logic             i_m1_we,
  input  logic [AW-1:0]    i_m1_addr,
  input  logic [WIDTH-1:0] i_m1_wdata,
  input  logic [SW-1:0]    i_m1_wstrb,
  output logic             o_m1_gnt,
  output logic             o_m1_rvalid,
  output logic [WIDTH-1:0] o_m1_rdata,
  output logic             o_ram_write_en,
  output logic [AW-1:0]    o_ram_addr,
  output logic [WIDTH-1:0] o_ram_data_i,
  input  logic [WIDTH-1:0] i_ram_data_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ACCESS    = 2'd1,
    S_RMW_READ  = 2'd2,
    S_RMW_WRITE = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_last;
  logic             r_id;
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [SW-1:0]    r_wstrb;
  logic             r_ram_we;
  logic [AW-1:0]    r_ram_addr;
  logic [WIDTH-1:0] r_ram_data;
  logic             r_rv0;
  logic             r_rv1;
  logic [WIDTH-1:0] r_rd0;
  logic [WIDTH-1:0] r_rd1;

  logic             w_idle;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_s_we;
  logic [AW-1:0]    w_s_addr;
  logic [WIDTH-1:0] w_s_wdata;
  logic [SW-1:0]    w_s_wstrb;
  logic             w_s_partial;
  logic [WIDTH-1:0] w_merge;

  // Grant is combinational so the requester sees it in the cycle it is accepted.
  assign w_idle = (r_state == S_IDLE);
  assign w_gnt1 = w_idle & i_reset_n & i_m1_req & (~i_m0_req | ~r_last);
  assign w_gnt0 = w_idle & i_reset_n & i_m0_req & ~w_gnt1;

  assign w_s_we      = w_gnt1 ? i_m1_we    : i_m0_we;
  assign w_s_addr    = w_gnt1 ? i_m1_addr  : i_m0_addr;
  assign w_s_wdata   = w_gnt1 ? i_m1_wdata : i_m0_wdata;
  assign w_s_wstrb   = w_gnt1 ? i_m1_wstrb : i_m0_wstrb;
  assign w_s_partial = w_s_we & (w_s_wstrb != {SW{1'b1}}) & (w_s_wstrb != {SW{1'b0}});

  for (genvar i = 0; i < SW; i++) begin : g_merge
    assign w_merge[8*i +: 8] = r_wstrb[i] ? r_wdata[8*i +: 8] : i_ram_data_o[8*i +: 8];
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_id       <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_rv0      <= 1'b0;
      r_rv1      <= 1'b0;
      r_rd0      <= '0;
      r_rd1      <= '0;
    end else begin
      r_rv0 <= 1'b0;
      r_rv1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ram_we <= 1'b0;
          if (w_gnt0 | w_gnt1) begin
            r_id       <= w_gnt1;
            r_last     <= w_gnt1;
            r_we       <= w_s_we;
            r_addr     <= w_s_addr;
            r_wdata    <= w_s_wdata;
            r_wstrb    <= w_s_wstrb;
            r_ram_addr <= w_s_addr;
            r_ram_data <= w_s_wdata;
            if (w_s_partial) begin
              r_state <= S_RMW_READ;
            end else begin
              // An all-zero strobe write walks through ACCESS without touching the RAM.
              r_ram_we <= w_s_we & (|w_s_wstrb);
              r_state  <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          r_ram_we <= 1'b0;
          if (!r_we) begin
            if (r_id) begin
              r_rv1 <= 1'b1;
              r_rd1 <= i_ram_data_o;
            end else begin
              r_rv0 <= 1'b1;
              r_rd0 <= i_ram_data_o;
            end
          end
          r_state <= S_IDLE;
        end
        S_RMW_READ: begin
          r_ram_data <= w_merge;
          r_ram_we   <= 1'b1;
          r_ram_addr <= r_addr;
          r_state    <= S_RMW_WRITE;
        end
        S_RMW_WRITE: begin
          r_ram_we <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_ram_we <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign o_m0_gnt       = w_gnt0;
  assign o_m1_gnt       = w_gnt1;
  assign o_m0_rvalid    = r_rv0;
  assign o_m1_rvalid    = r_rv1;
  assign o_m0_rdata     = r_rd0;
  assign o_m1_rdata     = r_rd1;
  assign o_ram_write_en = r_ram_we;
  assign o_ram_addr     = r_ram_addr;
  assign o_ram_data_i   = r_ram_data;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ram_port_arbiter : directed + random bench with a cycle-level reference model
// Rev 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [9:0]  addr0, addr1;
  logic [31:0] wd0, wd1;
  logic [3:0]  st0, st1;
  logic        gnt0, gnt1, rv0, rv1;
  logic [31:0] rd0, rd1;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_di;
  wire  [31:0] ram_do;

  logic [31:0] mem [0:1023];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_di;
  end
  assign ram_do = mem[ram_addr];

  ram_port_arbiter #(.WIDTH(32), .DEPTH(1024)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_m0_req(req0), .i_m0_we(we0), .i_m0_addr(addr0), .i_m0_wdata(wd0), .i_m0_wstrb(st0),
    .o_m0_gnt(gnt0), .o_m0_rvalid(rv0), .o_m0_rdata(rd0),
    .i_m1_req(req1), .i_m1_we(we1), .i_m1_addr(addr1), .i_m1_wdata(wd1), .i_m1_wstrb(st1),
    .o_m1_gnt(gnt1), .o_m1_rvalid(rv1), .o_m1_rdata(rd1),
    .o_ram_write_en(ram_we), .o_ram_addr(ram_addr), .o_ram_data_i(ram_di), .i_ram_data_o(ram_do)
  );

  // Reference model: shadow memory, busy-until cycle, one pending command.
  int          total = 0, bad = 0, cyc = 0;
  logic [31:0] ref_mem [0:15];
  int          free_at = 0, last_id = 1;
  bit          p_valid = 0, p_we = 0;
  int          p_t = 0;
  logic [9:0]  p_addr = '0;
  logic [31:0] p_wdata = '0;
  logic [3:0]  p_strb = '0;
  int          rv_at [2] = '{-1, -1};
  logic [31:0] rv_data [2] = '{32'd0, 32'd0};
  logic [31:0] exp_rd [2] = '{32'd0, 32'd0};
  bit          g0_seen, g1_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (new_w & m) | (old_w & ~m);
  endfunction

  function automatic bit is_partial(input logic [3:0] s);
    return (s != 4'hF) && (s != 4'h0);
  endfunction

  // One clock cycle: called in the low phase with inputs already driven.
  task automatic tick();
    bit          avail, e_g0, e_g1, e_we, part;
    int          k;
    logic [31:0] e_wd;
    #1;
    g0_seen = gnt0;
    g1_seen = gnt1;
    avail = rst_n && (cyc >= free_at);
    e_g1  = avail && req1 && (!req0 || last_id == 0);
    e_g0  = avail && req0 && !e_g1;
    chk("gnt0", 32'(gnt0), 32'(e_g0));
    chk("gnt1", 32'(gnt1), 32'(e_g1));

    part = p_we && is_partial(p_strb);
    e_we = 1'b0;
    e_wd = '0;
    if (p_valid && p_we) begin
      if (!part && p_strb != 4'h0 && cyc == p_t + 1) begin e_we = 1'b1; e_wd = p_wdata; end
      if (part && cyc == p_t + 2) begin
        e_we = 1'b1;
        e_wd = merge(ref_mem[p_addr[3:0]], p_wdata, p_strb);
      end
    end
    chk("ram_we", 32'(ram_we), 32'(e_we));
    if (p_valid && (cyc == p_t + 1 || (part && cyc == p_t + 2)))
      chk("ram_addr", 32'(ram_addr), 32'(p_addr));
    if (e_we) chk("ram_data", ram_di, e_wd);

    for (int j = 0; j < 2; j++) if (rv_at[j] == cyc) exp_rd[j] = rv_data[j];
    chk("m0_rvalid", 32'(rv0), 32'(rv_at[0] == cyc));
    chk("m1_rvalid", 32'(rv1), 32'(rv_at[1] == cyc));
    chk("m0_rdata", rd0, exp_rd[0]);
    chk("m1_rdata", rd1, exp_rd[1]);

    if (e_we) ref_mem[p_addr[3:0]] = e_wd;
    if (bd_we) ref_mem[bd_addr[3:0]] = bd_data;
    if (e_g0 || e_g1) begin
      k       = e_g1 ? 1 : 0;
      p_valid = 1'b1;
      p_t     = cyc;
      p_we    = k ? we1 : we0;
      p_addr  = k ? addr1 : addr0;
      p_wdata = k ? wd1 : wd0;
      p_strb  = k ? st1 : st0;
      free_at = cyc + ((p_we && is_partial(p_strb)) ? 3 : 2);
      last_id = k;
      if (!p_we) begin rv_at[k] = cyc + 2; rv_data[k] = ref_mem[p_addr[3:0]]; end
    end
    if (!rst_n) begin
      p_valid = 1'b0;
      rv_at   = '{-1, -1};
      exp_rd  = '{32'd0, 32'd0};
      free_at = cyc + 1;
      last_id = 1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic cmd(input int k, input bit we, input logic [9:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    if (k == 1) begin req1 = 1'b1; we1 = we; addr1 = a; wd1 = d; st1 = s; end
    else        begin req0 = 1'b1; we0 = we; addr0 = a; wd0 = d; st0 = s; end
  endtask

  task automatic rand_cmd(input int k);
    logic [3:0] s;
    case ($urandom_range(0, 3))
      0:       s = 4'hF;
      1:       s = 4'h0;
      default: s = 4'($urandom_range(0, 15));
    endcase
    cmd(k, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom, s);
  endtask

  task automatic wait_gnt(input int k);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      got = (k == 1) ? g1_seen : g0_seen;
    end
    chk("gnt_timeout", 32'(got), 32'd1);
    if (k == 1) req1 = 1'b0; else req0 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    req0 = 0; we0 = 0; addr0 = '0; wd0 = '0; st0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wd1 = '0; st1 = '0;
    @(posedge clk);
    @(negedge clk);

    // Reset held with both ports requesting; RAM preloaded through the backdoor meanwhile.
    cmd(0, 1'b0, 10'd0, 32'd0, 4'd0);
    cmd(1, 1'b0, 10'd1, 32'd0, 4'd0);
    for (int a = 0; a < 16; a++) begin
      bd_we   = 1'b1;
      bd_addr = 10'(a);
      case (a)
        3:       bd_data = 32'hAABBCCDD;
        4:       bd_data = 32'h12345678;
        5:       bd_data = 32'hDEADBEEF;
        default: bd_data = $urandom;
      endcase
      tick();
    end
    bd_we = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("t1_first_gnt_m0", 32'(g0_seen), 32'd1);
    req0 = 1'b0;
    wait_gnt(1);
    tick(); tick();

    // Single read of a known word.
    cmd(0, 1'b0, 10'd5, 32'd0, 4'd0);
    tick();
    chk("t2_gnt", 32'(g0_seen), 32'd1);
    req0 = 1'b0;
    tick(); tick();
    chk("t2_rdata", rd0, 32'hDEADBEEF);

    // Continuous contention: grants must alternate.
    cmd(0, 1'b0, 10'd8, 32'd0, 4'd0);
    cmd(1, 1'b0, 10'd9, 32'd0, 4'd0);
    for (int i = 0; i < 10; i++) tick();
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();

    // Partial write via read-modify-write.
    cmd(1, 1'b1, 10'd3, 32'h11223344, 4'b0101);
    wait_gnt(1);
    tick(); tick();
    chk("t4_mem", mem[3], 32'hAA22CC44);

    // Full write then read-back, then a zero-strobe no-op write.
    cmd(1, 1'b1, 10'd7, 32'h0BADF00D, 4'hF);
    wait_gnt(1);
    cmd(0, 1'b0, 10'd7, 32'd0, 4'd0);
    wait_gnt(0);
    tick(); tick();
    chk("t5_rdata", rd0, 32'h0BADF00D);
    cmd(1, 1'b1, 10'd7, 32'hFFFFFFFF, 4'h0);
    wait_gnt(1);
    tick(); tick();
    chk("t5_nop_mem", mem[7], 32'h0BADF00D);

    // Reset landing on RMW_READ must abandon the write.
    cmd(0, 1'b1, 10'd4, 32'hFFFFFFFF, 4'b0011);
    wait_gnt(0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("t6_mem", mem[4], 32'h12345678);
    cmd(1, 1'b0, 10'd4, 32'd0, 4'd0);
    tick();
    chk("t6_gnt", 32'(g1_seen), 32'd1);
    req1 = 1'b0;
    tick(); tick();
    chk("t6_rdata", rd1, 32'h12345678);

    // Random traffic with withdrawals and occasional resets.
    for (int n = 0; n < 600; n++) begin
      tick();
      if (g0_seen) req0 = 1'b0;
      else if (req0) begin if ($urandom_range(0, 11) == 0) req0 = 1'b0; end
      else if ($urandom_range(0, 2) != 0) rand_cmd(0);
      if (g1_seen) req1 = 1'b0;
      else if (req1) begin if ($urandom_range(0, 11) == 0) req1 = 1'b0; end
      else if ($urandom_range(0, 2) != 0) rand_cmd(1);
      rst_n = ($urandom_range(0, 149) != 0);
    end
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    for (int a = 0; a < 16; a++) chk("final_mem", mem[a], ref_mem[a]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
